// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters; combinational lookup, 1-cycle training.
// Optional BTB_BYPASS_EN forwards a same-cycle update to a lookup of the same index.
module btb_predictor #(
    parameter int PC_WIDTH = 32,
    parameter int ENTRIES  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] IF_PC,
    output logic                BTB_Hit,
    output logic [PC_WIDTH-1:0] BTB_PC,
    input  logic                EX_Branch,
    input  logic [PC_WIDTH-1:0] EX_PC,
    input  logic                EX_Taken,
    input  logic [PC_WIDTH-1:0] EX_Target,
    input  logic                D_Cache_Stall,
    input  logic                BTB_Flush
);
    localparam int IDX = $clog2(ENTRIES);
    localparam int TW  = PC_WIDTH - IDX - 2;

    logic                valid_q [ENTRIES];
    logic                valid_d [ENTRIES];
    logic [TW-1:0]       tag_q   [ENTRIES];
    logic [TW-1:0]       tag_d   [ENTRIES];
    logic [PC_WIDTH-1:0] tgt_q   [ENTRIES];
    logic [PC_WIDTH-1:0] tgt_d   [ENTRIES];
    logic [1:0]          ctr_q   [ENTRIES];
    logic [1:0]          ctr_d   [ENTRIES];

    logic [IDX-1:0]      rd_idx, wr_idx;
    logic [TW-1:0]       rd_tag, wr_tag;
    logic                upd, wr_match;
    logic                nxt_valid;
    logic [TW-1:0]       nxt_tag;
    logic [PC_WIDTH-1:0] nxt_tgt;
    logic [1:0]          nxt_ctr;
    logic                rd_valid;
    logic [TW-1:0]       rd_etag;
    logic [PC_WIDTH-1:0] rd_tgt;
    logic [1:0]          rd_ctr;
    logic                rd_hit;
    logic                unused_pc_lsbs;

    assign rd_idx = IF_PC[IDX+1:2];
    assign rd_tag = IF_PC[PC_WIDTH-1:IDX+2];
    assign wr_idx = EX_PC[IDX+1:2];
    assign wr_tag = EX_PC[PC_WIDTH-1:IDX+2];
    assign unused_pc_lsbs = ^{IF_PC[1:0], EX_PC[1:0]};

    assign upd = EX_Branch & ~D_Cache_Stall & ~BTB_Flush;

    // Post-update image of the entry addressed by EX_PC; shared by the write port and the bypass path.
    always_comb begin
        wr_match  = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
        nxt_valid = valid_q[wr_idx];
        nxt_tag   = tag_q[wr_idx];
        nxt_tgt   = tgt_q[wr_idx];
        nxt_ctr   = ctr_q[wr_idx];
        if (wr_match) begin
            if (EX_Taken) begin
                nxt_ctr = (ctr_q[wr_idx] == 2'b11) ? 2'b11 : ctr_q[wr_idx] + 2'd1;
                nxt_tgt = EX_Target;
            end else begin
                nxt_ctr = (ctr_q[wr_idx] == 2'b00) ? 2'b00 : ctr_q[wr_idx] - 2'd1;
            end
        end else if (EX_Taken) begin
            nxt_valid = 1'b1;
            nxt_tag   = wr_tag;
            nxt_tgt   = EX_Target;
            nxt_ctr   = 2'b10;
        end
    end

    // Flush only drops valid bits and wins over a same-cycle update.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        if (BTB_Flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_d[i] = 1'b0;
            end
        end else if (upd) begin
            valid_d[wr_idx] = nxt_valid;
            tag_d[wr_idx]   = nxt_tag;
            tgt_d[wr_idx]   = nxt_tgt;
            ctr_d[wr_idx]   = nxt_ctr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= 2'b01;
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            ctr_q   <= ctr_d;
        end
    end

    always_comb begin
        rd_valid = valid_q[rd_idx];
        rd_etag  = tag_q[rd_idx];
        rd_tgt   = tgt_q[rd_idx];
        rd_ctr   = ctr_q[rd_idx];
`ifdef BTB_BYPASS_EN
        if (upd && (wr_idx == rd_idx)) begin
            rd_valid = nxt_valid;
            rd_etag  = nxt_tag;
            rd_tgt   = nxt_tgt;
            rd_ctr   = nxt_ctr;
        end
`endif
        rd_hit = rd_valid && (rd_etag == rd_tag) && rd_ctr[1] && !rst;
    end

    assign BTB_Hit = rd_hit;
    assign BTB_PC  = rd_hit ? rd_tgt : '0;

endmodule
